// File: rtl/game_io_pkg.sv
// Shared constants for the game I/O bridge: command opcodes, status-word bit
// positions and command-word field positions.
package game_io_pkg;

  typedef enum logic [3:0] {
    OP_NOP          = 4'd0,
    OP_CLEAR_EVENTS = 4'd1,
    OP_SET_SCORE    = 4'd2,
    OP_SET_LEDS     = 4'd3,
    OP_RESET_FRAME  = 4'd4
  } opcode_e;

  // r20 status word bit positions
  localparam int ST_JUMP_LVL = 0;
  localparam int ST_DUCK_LVL = 1;
  localparam int ST_JUMP_EVT = 2;
  localparam int ST_DUCK_EVT = 3;
  localparam int ST_TICK     = 4;
  localparam int ST_ACK      = 31;

  // r16 command word fields
  localparam int CMD_TOGGLE_BIT = 31;
  localparam int CMD_OP_MSB     = 3;
  localparam int CMD_OP_LSB     = 0;

  // CLEAR_EVENTS mask bits carried in r17
  localparam int CLR_JUMP = 0;
  localparam int CLR_DUCK = 1;
  localparam int CLR_TICK = 2;

endpackage

// File: rtl/io_debouncer.sv
// Two-flop synchronizer followed by a stability counter; the debounced level
// flips only after DEBOUNCE_CYCLES consecutive mismatching cycles.
module io_debouncer #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  logic [1:0]  r_sync;
  logic [15:0] r_cnt;
  logic        r_level;
  logic        w_mismatch;
  logic        w_flip;

  assign w_mismatch = r_sync[1] ^ r_level;
  assign w_flip     = w_mismatch && (r_cnt == DEBOUNCE_CYCLES - 16'd1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b00;
      r_cnt   <= 16'd0;
      r_level <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      if (w_flip) begin
        r_level <= r_sync[1];
        r_cnt   <= 16'd0;
      end else if (w_mismatch) begin
        r_cnt <= r_cnt + 16'd1;
      end else begin
        r_cnt <= 16'd0;
      end
    end
  end

  assign o_level = r_level;
  // Strobe coincides with the edge that raises the level, so the press event
  // and the level become visible together.
  assign o_rise  = w_flip & r_sync[1];

endmodule

// File: rtl/game_io_bridge.sv
// Peripheral side of the memory-mapped game I/O registers: button debounce and
// press latching, frame tick generation, and toggle-handshake command execution.
module game_io_bridge
  import game_io_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [31:0] TICK_DIV        = 32'd833333
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        btn_jump_raw,
  input  logic        btn_duck_raw,
  input  logic [31:0] r16,
  input  logic [31:0] r17,
  output logic [31:0] r20,
  output logic [31:0] r22,
  output logic [15:0] score,
  output logic [7:0]  leds
);

  logic        w_jump_lvl;
  logic        w_jump_rise;
  logic        w_duck_lvl;
  logic        w_duck_rise;

  logic        r_ack;
  logic        r_jump_evt;
  logic        r_duck_evt;
  logic        r_tick_pend;
  logic [31:0] r_div;
  logic [31:0] r_frame;
  logic [15:0] r_score;
  logic [7:0]  r_leds;

  logic        w_pending;
  opcode_e     w_op;
  logic        w_wrap;
  logic        w_clr_jump;
  logic        w_clr_duck;
  logic        w_clr_tick;
  logic        w_set_score;
  logic        w_set_leds;
  logic        w_reset_frame;
  logic        w_unused;

  io_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_jump_db (
    .clk    (clock),
    .rst_n  (ctrl_reset),
    .i_raw  (btn_jump_raw),
    .o_level(w_jump_lvl),
    .o_rise (w_jump_rise)
  );

  io_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_duck_db (
    .clk    (clock),
    .rst_n  (ctrl_reset),
    .i_raw  (btn_duck_raw),
    .o_level(w_duck_lvl),
    .o_rise (w_duck_rise)
  );

  assign w_pending = r16[CMD_TOGGLE_BIT] ^ r_ack;
  assign w_op      = opcode_e'(r16[CMD_OP_MSB:CMD_OP_LSB]);
  assign w_wrap    = (r_div == TICK_DIV - 32'd1);
  assign w_unused  = ^{r16[30:4], r17[31:16]};

  // NOTE: every always_comb output gets a default before any branch; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    w_clr_jump    = 1'b0;
    w_clr_duck    = 1'b0;
    w_clr_tick    = 1'b0;
    w_set_score   = 1'b0;
    w_set_leds    = 1'b0;
    w_reset_frame = 1'b0;
    if (w_pending) begin
      case (w_op)
        OP_CLEAR_EVENTS: begin
          w_clr_jump = r17[CLR_JUMP];
          w_clr_duck = r17[CLR_DUCK];
          w_clr_tick = r17[CLR_TICK];
        end
        OP_SET_SCORE:   w_set_score   = 1'b1;
        OP_SET_LEDS:    w_set_leds    = 1'b1;
        OP_RESET_FRAME: w_reset_frame = 1'b1;
        default:        ;
      endcase
    end
  end

  // Ack toggles once per observed request, which retires the pending condition.
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      r_ack   <= 1'b0;
      r_score <= 16'd0;
      r_leds  <= 8'd0;
    end else begin
      if (w_pending)   r_ack   <= ~r_ack;
      if (w_set_score) r_score <= r17[15:0];
      if (w_set_leds)  r_leds  <= r17[7:0];
    end
  end

  // RESET_FRAME overrides the counter update but not the tick on a wrap cycle.
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      r_div   <= 32'd0;
      r_frame <= 32'd0;
    end else if (w_reset_frame) begin
      r_div   <= 32'd0;
      r_frame <= 32'd0;
    end else if (w_wrap) begin
      r_div   <= 32'd0;
      r_frame <= r_frame + 32'd1;
    end else begin
      r_div <= r_div + 32'd1;
    end
  end

  // Sticky bits: a set in the same cycle as a clear wins.
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      r_jump_evt  <= 1'b0;
      r_duck_evt  <= 1'b0;
      r_tick_pend <= 1'b0;
    end else begin
      r_jump_evt  <= w_jump_rise | (r_jump_evt  & ~w_clr_jump);
      r_duck_evt  <= w_duck_rise | (r_duck_evt  & ~w_clr_duck);
      r_tick_pend <= w_wrap      | (r_tick_pend & ~w_clr_tick);
    end
  end

  always_comb begin
    r20              = 32'd0;
    r20[ST_JUMP_LVL] = w_jump_lvl;
    r20[ST_DUCK_LVL] = w_duck_lvl;
    r20[ST_JUMP_EVT] = r_jump_evt;
    r20[ST_DUCK_EVT] = r_duck_evt;
    r20[ST_TICK]     = r_tick_pend;
    r20[ST_ACK]      = r_ack;
  end

  assign r22   = r_frame;
  assign score = r_score;
  assign leds  = r_leds;

endmodule

// File: tb/tb_game_io_bridge.sv
// Self-checking bench for game_io_bridge with DEBOUNCE_CYCLES=4, TICK_DIV=8:
// directed scenarios plus randomized commands against an arithmetic model.
module tb_game_io_bridge;

  localparam logic [15:0] DEB  = 16'd4;
  localparam logic [31:0] TDIV = 32'd8;
  localparam int          TD   = 8;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        btn_jump_raw;
  logic        btn_duck_raw;
  logic [31:0] r16;
  logic [31:0] r17;
  logic [31:0] r20;
  logic [31:0] r22;
  logic [15:0] score;
  logic [7:0]  leds;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_no = 0;

  game_io_bridge #(.DEBOUNCE_CYCLES(DEB), .TICK_DIV(TDIV)) dut (
    .clock       (clock),
    .ctrl_reset  (ctrl_reset),
    .btn_jump_raw(btn_jump_raw),
    .btn_duck_raw(btn_duck_raw),
    .r16         (r16),
    .r17         (r17),
    .r20         (r20),
    .r22         (r22),
    .score       (score),
    .leds        (leds)
  );

  always #5 clock = ~clock;

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      edge_no++;
    end
    #1;
  endtask

  task automatic do_reset(input logic jump, input logic duck);
    btn_jump_raw = jump;
    btn_duck_raw = duck;
    r16 = 32'd0;
    r17 = 32'd0;
    ctrl_reset = 1'b0;
    step(3);
    ctrl_reset = 1'b1;
    edge_no = 0;
  endtask

  task automatic test_reset();
    btn_jump_raw = 1'b1;
    btn_duck_raw = 1'b0;
    r16 = 32'd0;
    r17 = 32'd0;
    ctrl_reset = 1'b0;
    step(4);
    n_tests++; if (r20 !== 32'd0) begin n_fail++; $display("FAIL reset_r20: got %h want %h", r20, 32'd0); end
    n_tests++; if (r22 !== 32'd0) begin n_fail++; $display("FAIL reset_r22: got %h want %h", r22, 32'd0); end
    n_tests++; if (score !== 16'd0) begin n_fail++; $display("FAIL reset_score: got %h want %h", score, 16'd0); end
    n_tests++; if (leds !== 8'd0) begin n_fail++; $display("FAIL reset_leds: got %h want %h", leds, 8'd0); end
    ctrl_reset = 1'b1;
    edge_no = 0;
    step(5);
    n_tests++; if (r20 !== 32'd0) begin n_fail++; $display("FAIL reset_early_r20: got %h want %h", r20, 32'd0); end
    step(1);
    n_tests++; if (r20 !== 32'h5) begin n_fail++; $display("FAIL reset_release_r20: got %h want %h", r20, 32'h5); end
    n_tests++; if (r22 !== 32'd0) begin n_fail++; $display("FAIL reset_release_r22: got %h want %h", r22, 32'd0); end
  endtask

  task automatic test_bounce();
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      btn_jump_raw = ((i / 2) % 2) == 0;
      step(1);
      n_tests++;
      if (r20[0] !== 1'b0 || r20[2] !== 1'b0) begin
        n_fail++; $display("FAIL bounce_cycle%0d: got lvl=%b evt=%b want 0 0", i, r20[0], r20[2]);
      end
    end
    btn_jump_raw = 1'b0;
    step(8);
    n_tests++;
    if (r20[0] !== 1'b0 || r20[2] !== 1'b0) begin
      n_fail++; $display("FAIL bounce_settled: got lvl=%b evt=%b want 0 0", r20[0], r20[2]);
    end
  endtask

  task automatic test_frame_tick();
    do_reset(1'b0, 1'b0);
    step(80);
    n_tests++; if (r22 !== 32'd10) begin n_fail++; $display("FAIL tick_r22: got %0d want 10", r22); end
    n_tests++; if (r20[4] !== 1'b1) begin n_fail++; $display("FAIL tick_pending: got %b want 1", r20[4]); end
    r17 = 32'd4;
    step(1);
    r16 = 32'h8000_0001;
    step(1);
    n_tests++; if (r20[31] !== 1'b1) begin n_fail++; $display("FAIL tick_clr_ack: got %b want 1", r20[31]); end
    n_tests++; if (r20[4] !== 1'b0) begin n_fail++; $display("FAIL tick_clr_bit: got %b want 0", r20[4]); end
    n_tests++; if (r22 !== 32'd10) begin n_fail++; $display("FAIL tick_clr_r22: got %0d want 10", r22); end
  endtask

  task automatic test_handshake();
    do_reset(1'b0, 1'b0);
    r17 = 32'h0000_1234;
    step(1);
    n_tests++; if (r20[31] !== 1'b0) begin n_fail++; $display("FAIL hs_ack_idle: got %b want 0", r20[31]); end
    r16 = 32'h8000_0002;
    step(1);
    n_tests++; if (score !== 16'h1234) begin n_fail++; $display("FAIL hs_score: got %h want 1234", score); end
    n_tests++; if (r20[31] !== 1'b1) begin n_fail++; $display("FAIL hs_ack1: got %b want 1", r20[31]); end
    r17 = 32'h0000_DEAD;
    for (int i = 0; i < 10; i++) begin
      step(1);
      n_tests++;
      if (score !== 16'h1234 || r20[31] !== 1'b1) begin
        n_fail++; $display("FAIL hs_hold%0d: got score=%h ack=%b want 1234 1", i, score, r20[31]);
      end
    end
    r17 = 32'h0000_00AA;
    step(1);
    r16 = 32'h0000_0003;
    step(1);
    n_tests++; if (leds !== 8'hAA) begin n_fail++; $display("FAIL hs_leds: got %h want aa", leds); end
    n_tests++; if (r20[31] !== 1'b0) begin n_fail++; $display("FAIL hs_ack0: got %b want 0", r20[31]); end
    n_tests++; if (score !== 16'h1234) begin n_fail++; $display("FAIL hs_score_kept: got %h want 1234", score); end
  endtask

  task automatic test_set_wins();
    do_reset(1'b0, 1'b0);
    r17 = 32'd1;
    btn_jump_raw = 1'b1;
    step(5);
    r16 = 32'h8000_0001;
    step(1);
    n_tests++; if (r20[2] !== 1'b1) begin n_fail++; $display("FAIL race_evt: got %b want 1", r20[2]); end
    n_tests++; if (r20[0] !== 1'b1) begin n_fail++; $display("FAIL race_lvl: got %b want 1", r20[0]); end
    n_tests++; if (r20[31] !== 1'b1) begin n_fail++; $display("FAIL race_ack: got %b want 1", r20[31]); end
    r16 = 32'h0000_0001;
    step(1);
    n_tests++; if (r20[2] !== 1'b0) begin n_fail++; $display("FAIL race_later_clr: got %b want 0", r20[2]); end
    n_tests++; if (r20[0] !== 1'b1) begin n_fail++; $display("FAIL race_lvl_kept: got %b want 1", r20[0]); end
    btn_jump_raw = 1'b0;
    step(8);
    n_tests++; if (r20[2] !== 1'b0 || r20[0] !== 1'b0) begin
      n_fail++; $display("FAIL fall_no_evt: got lvl=%b evt=%b want 0 0", r20[0], r20[2]);
    end
  endtask

  task automatic test_wrap_reset();
    do_reset(1'b0, 1'b0);
    step(9);
    r17 = 32'd4;
    r16 = 32'h8000_0001;
    step(1);
    n_tests++; if (r20[4] !== 1'b0) begin n_fail++; $display("FAIL wrap_preclr: got %b want 0", r20[4]); end
    n_tests++; if (r22 !== 32'd1) begin n_fail++; $display("FAIL wrap_pre_r22: got %0d want 1", r22); end
    step(5);
    r17 = 32'd0;
    r16 = 32'h0000_0004;
    step(1);
    n_tests++; if (r22 !== 32'd0) begin n_fail++; $display("FAIL wrap_rf_r22: got %0d want 0", r22); end
    n_tests++; if (r20[4] !== 1'b1) begin n_fail++; $display("FAIL wrap_rf_tick: got %b want 1", r20[4]); end
    step(7);
    n_tests++; if (r22 !== 32'd0) begin n_fail++; $display("FAIL wrap_next_early: got %0d want 0", r22); end
    step(1);
    n_tests++; if (r22 !== 32'd1) begin n_fail++; $display("FAIL wrap_next: got %0d want 1", r22); end
    btn_jump_raw = 1'b1;
    step(3);
    ctrl_reset = 1'b0;
    btn_jump_raw = 1'b0;
    step(1);
    n_tests++; if (r20 !== 32'd0) begin n_fail++; $display("FAIL middb_in_reset: got %h want 0", r20); end
    ctrl_reset = 1'b1;
    edge_no = 0;
    step(10);
    n_tests++; if (r20[0] !== 1'b0 || r20[2] !== 1'b0) begin
      n_fail++; $display("FAIL middb_after: got lvl=%b evt=%b want 0 0", r20[0], r20[2]);
    end
  endtask

  // Model: frames = completed TICK_DIV periods since the last frame origin;
  // tick pending = the latest wrap edge is at or after the latest tick clear.
  int origin, rec_wrap, last_clear;

  function automatic int last_wrap_upto(input int n);
    int w;
    w = origin + TD * ((n - origin) / TD);
    if (w > origin && w > rec_wrap) return w;
    return rec_wrap;
  endfunction

  task automatic test_random_cmds();
    logic        m_ack;
    logic [15:0] m_score;
    logic [7:0]  m_leds;
    logic        m_tick;
    logic [31:0] exp_r20;
    logic [31:0] arg;
    logic [3:0]  op;
    int          sel, e, lw;
    do_reset(1'b0, 1'b0);
    origin = 0; rec_wrap = -1; last_clear = -1;
    m_ack = 1'b0; m_score = 16'd0; m_leds = 8'd0;
    for (int k = 0; k < 60; k++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2: op = 4'd1;
        3:       op = 4'd2;
        4:       op = 4'd3;
        5, 6:    op = 4'd4;
        7:       op = 4'd0;
        default: op = 4'($urandom_range(5, 15));
      endcase
      arg = $urandom();
      if ($urandom_range(0, 3) != 0) step($urandom_range(1, 6));
      r17 = arg;
      step(1);
      r16 = $urandom();
      r16[31] = ~m_ack;
      r16[3:0] = op;
      step(1);
      e = edge_no;
      m_ack = ~m_ack;
      if (op == 4'd1 && arg[2]) last_clear = e;
      if (op == 4'd2) m_score = arg[15:0];
      if (op == 4'd3) m_leds = arg[7:0];
      if (op == 4'd4) begin
        rec_wrap = last_wrap_upto(e);
        origin = e;
      end
      lw = last_wrap_upto(e);
      m_tick = (lw >= 0) && (lw >= last_clear);
      exp_r20 = 32'd0;
      exp_r20[31] = m_ack;
      exp_r20[4] = m_tick;
      n_tests++; if (r20 !== exp_r20) begin n_fail++; $display("FAIL rnd%0d_r20 op=%0d: got %h want %h", k, op, r20, exp_r20); end
      n_tests++; if (r22 !== 32'((e - origin) / TD)) begin n_fail++; $display("FAIL rnd%0d_r22 op=%0d: got %0d want %0d", k, op, r22, (e - origin) / TD); end
      n_tests++; if (score !== m_score) begin n_fail++; $display("FAIL rnd%0d_score: got %h want %h", k, score, m_score); end
      n_tests++; if (leds !== m_leds) begin n_fail++; $display("FAIL rnd%0d_leds: got %h want %h", k, leds, m_leds); end
    end
  endtask

  initial begin
    ctrl_reset = 1'b0;
    btn_jump_raw = 1'b0;
    btn_duck_raw = 1'b0;
    r16 = 32'd0;
    r17 = 32'd0;
    test_reset();
    test_bounce();
    test_frame_tick();
    test_handshake();
    test_set_wins();
    test_wrap_reset();
    test_random_cmds();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
